// File: rtl/neural_connect_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel among NUM_REQUESTERS producers, with bursts of up to BURST_LEN beats.
// Optional: define NC_ARB_BEAT_COUNT_EN to add a 32-bit accepted-beat counter output (beat_count).
module neural_connect_arbiter #(
    parameter int NUM_REQUESTERS  = 4,
    parameter int NUM_DATA_INPUTS = 1,
    parameter int DATA_WIDTH      = 8,
    parameter int BURST_LEN       = 4,
    parameter int CNT_W           = $clog2(BURST_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQUESTERS-1:0] req_valid,
    input  logic [DATA_WIDTH-1:0]     req_data [NUM_REQUESTERS][NUM_DATA_INPUTS],
    output logic [NUM_REQUESTERS-1:0] req_ready,
    output logic                      data_out_valid,
    output logic [DATA_WIDTH-1:0]     data_out [NUM_DATA_INPUTS],
    input  logic                      data_out_ready,
    output logic [NUM_REQUESTERS-1:0] grant,
    output logic                      busy
`ifdef NC_ARB_BEAT_COUNT_EN
    ,
    output logic [31:0]               beat_count
`endif
);
    localparam int IDX_W = $clog2(NUM_REQUESTERS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] gidx, rr_ptr, win_idx;
    logic             win_found;
    logic [CNT_W-1:0] beat_cnt;
    logic             beat;
    int               scan;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = 0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            scan = (int'(rr_ptr) + i) % NUM_REQUESTERS;
            if (!win_found && req_valid[scan]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(scan);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = GRANT;
            GRANT:   if ((beat && beat_cnt == LAST_BEAT) || !req_valid[gidx]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state == GRANT);
        data_out_valid = busy & req_valid[gidx];
        req_ready      = grant & {NUM_REQUESTERS{data_out_ready}};
        beat           = data_out_valid & data_out_ready;
        for (int k = 0; k < NUM_DATA_INPUTS; k++)
            data_out[k] = busy ? req_data[gidx][k] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= '0;
            gidx     <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else if (state == IDLE) begin
            if (win_found) begin
                grant    <= NUM_REQUESTERS'(1) << win_idx;
                gidx     <= win_idx;
                beat_cnt <= '0;
                rr_ptr   <= (int'(win_idx) == NUM_REQUESTERS - 1) ? '0 : win_idx + 1'b1;
            end
        end else if (state_nxt == IDLE) begin
            grant    <= '0;
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

`ifdef NC_ARB_BEAT_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    beat_count <= '0;
        else if (beat) beat_count <= beat_count + 32'd1;
    end
`endif

endmodule

// File: doc/neural_connect_arbiter.md
Name: neural_connect_arbiter

Overview:
- Round-robin arbiter that shares one downstream valid/ready data channel between NUM_REQUESTERS upstream producers.
- The downstream channel is typically an intermediate buffer chain in the neuralConnect fabric.
- Grants one requester at a time for a burst of up to BURST_LEN accepted beats, then rotates priority.
- Forwards the granted requester's multi-word data vector unchanged.

Parameters:
- NUM_REQUESTERS, 4: number of upstream requesters, ≥2.
- NUM_DATA_INPUTS, 1: parallel data words per beat.
- DATA_WIDTH, 8: bits per data word.
- BURST_LEN, 4: maximum beats per grant, ≥1.
- CNT_W, $clog2(BURST_LEN+1): local beat-counter width; not overridden.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, NUM_REQUESTERS: per-requester valid.
- req_data, input, DATA_WIDTH x [NUM_REQUESTERS-1:0][NUM_DATA_INPUTS-1:0]: per-requester data (unpacked arrays).
- req_ready, output, NUM_REQUESTERS: per-requester ready; at most one bit high.
- data_out_valid, output, 1: downstream valid.
- data_out, output, DATA_WIDTH x [NUM_DATA_INPUTS-1:0]: downstream data (unpacked array).
- data_out_ready, input, 1: downstream ready.
- grant, output, NUM_REQUESTERS: one-hot current grant; all zero when idle.
- busy, output, 1: high in GRANT state.

Behaviour:
- Reset (async assert, sync-release style sampling): state=IDLE, grant=0, rr_ptr=0, beat_cnt=0. Outputs: req_ready=0, data_out_valid=0, busy=0. data_out is don't-care but must drive zeros while grant=0.
- State IDLE:
  - Scan req_valid starting at index rr_ptr, wrapping modulo NUM_REQUESTERS. The first set bit wins.
  - If a winner exists: next state=GRANT, grant<=onehot(winner), beat_cnt<=0, rr_ptr<=(winner+1) mod NUM_REQUESTERS.
  - If no winner: stay in IDLE, rr_ptr unchanged.
  - The arbitration cycle is a one-cycle bubble: no data passes in IDLE.
- State GRANT, requester g:
  - data_out_valid = req_valid[g]; data_out = req_data[g]; req_ready[g] = data_out_ready; all other req_ready bits = 0. These are combinational from the registered grant.
  - Beat: data_out_valid & data_out_ready. On a beat, beat_cnt increments.
  - Leave GRANT on a beat when beat_cnt==BURST_LEN-1 (burst complete): next state IDLE, grant<=0.
  - Also leave GRANT when req_valid[g]==0 on a clock edge (requester relinquishes): next state IDLE, grant<=0. This holds even mid-burst.
  - Otherwise stay in GRANT. A stalled downstream (ready low) holds the grant indefinitely; there is no timeout.
- Fairness: after a grant ends, every other valid requester is served before g again. Worst-case wait is (NUM_REQUESTERS-1) x (BURST_LEN+1) beat-opportunities.
- Simultaneous events:
  - Final beat and new requests in the same cycle: IDLE arbitration happens on the next cycle. Back-to-back grants are therefore separated by exactly one idle cycle.
  - Valid dropping in the same cycle as the final beat: not possible (a beat requires valid); the burst-complete rule applies.
- Reset mid-operation: all state clears immediately. In-flight beats are abandoned and no partial-state recovery occurs.
- Handshake compliance: the arbiter never asserts req_ready without a grant and never changes grant while data_out_valid & ~data_out_ready.

Optional Feature:
- Macro: NC_ARB_BEAT_COUNT_EN.
- Defined: adds output port beat_count [31:0].
  - Counts total accepted downstream beats.
  - Reset to 0; wraps 0xFFFFFFFF→0.
  - Increments on every data_out_valid & data_out_ready.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, req_valid=0 for 10 cycles -> grant=0, busy=0, data_out_valid=0, req_ready=0 throughout.
- Only req 2 valid continuously, data_out_ready=1, BURST_LEN=4 -> 4 beats with grant=0100, then 1 idle cycle, then regrant of req 2. Pattern repeats (4 beats per 5 cycles).
- All 4 requesters valid, ready=1 -> grant order 0,1,2,3,0…; each burst 4 beats; data_out equals the matching req_data values (tag data with requester id + sequence number).
- Req 1 granted, drops valid after 2 beats -> grant returns to 0 next cycle; beat_cnt reset; next arbitration starts at rr_ptr=2.
- Req 0 granted, data_out_ready=0 for 20 cycles -> grant held, data_out stable, req_ready[0]=0. Ready released -> remaining beats complete in order.
- With NC_ARB_BEAT_COUNT_EN: after 37 beats beat_count=37. Assert rst_n=0 mid-burst -> beat_count=0, grant=0 asynchronously.
